// File: rtl/minimig_m68k_initiator_if.sv
// minimig_m68k_initiator_if
//   CPU-side bus pins of the Minimig 68000 bus, as driven by an initiator
//   running asynchronous 68000-style bus cycles.
//
//   _as          address strobe, low while a cycle is addressed
//   _uds, _lds   upper/lower data strobes
//   r_w          1 = read, 0 = write
//   address      word address [23:1]
//   data_out     write data from the initiator
//   data_oe      initiator drives data_out
//   data_in      read data from the responder
//   _dtack       data acknowledge from the responder (asynchronous)
//
//   master modport: the initiator side. slave modport: the responder side.
interface minimig_m68k_initiator_if;
  logic        _as;
  logic        _uds;
  logic        _lds;
  logic        r_w;
  logic [23:1] address;
  logic [15:0] data_out;
  logic        data_oe;
  logic [15:0] data_in;
  logic        _dtack;

  modport master (
    output _as, _uds, _lds, r_w, address, data_out, data_oe,
    input  data_in, _dtack
  );

  modport slave (
    input  _as, _uds, _lds, r_w, address, data_out, data_oe,
    output data_in, _dtack
  );
endinterface

// File: rtl/minimig_m68k_initiator.sv
// minimig_m68k_initiator
//   Bus master that runs one 68000-style asynchronous bus cycle per host/DMA
//   request on the Minimig CPU-side bus while the CPU is halted. A single
//   word request is turned into address, strobe and data phases S0..S7,
//   with wait states inserted until the responder asserts _dtack.
//
//   Ports
//     clk        28 MHz system clock
//     _reset     synchronous active-low reset
//     clk7_en    7 MHz enable, CPU_CLK rising half
//     clk7n_en   7 MHz enable, CPU_CLK falling half
//     req        request, held high until req_ack or req_err
//     req_we     1 = write, 0 = read
//     req_bs     byte selects [1]=upper [0]=lower, 00 is rejected
//     req_adr    word address [23:1]
//     req_wdat   write data
//     req_rdat   read data, valid with req_ack
//     req_ack    one-clk pulse, cycle complete
//     req_err    one-clk pulse, cycle aborted or illegal byte selects
//     busy       high from accept until ack/err
//     bus        CPU bus pins (master modport)
//
//   Parameters
//     TIMEOUT_W  width of the wait-state counter
//     TIMEOUT    wait ticks before abort
//
//   Build option
//     BUS_TIMEOUT_EN  when defined, a wait-state counter aborts a cycle that
//                     has spent TIMEOUT ticks in WAIT; the request then ends
//                     with req_err and req_rdat is left untouched. When not
//                     defined, WAIT lasts until _dtack.
//
//   A tick is clk7_en | clk7n_en; every bus phase advances on ticks only.
//   Each state is entered on a tick and its actions take effect on entry,
//   except that strobe release is done on the tick that ends S7.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for req on a clk7_en tick
//   S0    | address and r_w driven, strobes high
//   S1    | address setup
//   S2    | _as low; read data strobes low
//   S3    | write data driven, data_oe high
//   S4    | write data strobes low; _dtack sampled at its end
//   WAIT  | wait states until _dtack (or timeout)
//   S5    | data phase
//   S6    | read data captured at its end
//   S7    | strobes and r_w released at its end
//   DONE  | data_oe off, ack/err pulse, back to IDLE
module minimig_m68k_initiator #(
  parameter int TIMEOUT_W = 8,
  parameter int TIMEOUT   = 200
) (
  input  logic                    clk,
  input  logic                    _reset,
  input  logic                    clk7_en,
  input  logic                    clk7n_en,
  input  logic                    req,
  input  logic                    req_we,
  input  logic [1:0]              req_bs,
  input  logic [23:1]             req_adr,
  input  logic [15:0]             req_wdat,
  output logic [15:0]             req_rdat,
  output logic                    req_ack,
  output logic                    req_err,
  output logic                    busy,
  minimig_m68k_initiator_if.master bus
);

  // The counter must be able to hold TIMEOUT-1 and the limit must be nonzero.
  if (TIMEOUT < 1 || TIMEOUT > (1 << TIMEOUT_W)) begin : g_timeout_range
    $error("minimig_m68k_initiator: TIMEOUT out of range for TIMEOUT_W");
  end

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_S0,
    ST_S1,
    ST_S2,
    ST_S3,
    ST_S4,
    ST_WAIT,
    ST_S5,
    ST_S6,
    ST_S7,
    ST_DONE
  } state_t;

  state_t      state;
  logic        tick;
  logic        dtack_s1;
  logic        dtack_s2;
  logic        lat_we;
  logic [1:0]  lat_bs;
  logic [15:0] lat_wdat;

`ifdef BUS_TIMEOUT_EN
  localparam logic [TIMEOUT_W-1:0] WAIT_LAST = TIMEOUT_W'(TIMEOUT - 1);
  logic [TIMEOUT_W-1:0] wait_cnt;
  logic                 timed_out;
`endif

  assign tick = clk7_en | clk7n_en;

  // _dtack comes from an unrelated responder; resynchronise before use.
  always_ff @(posedge clk) begin
    if (!_reset) begin
      dtack_s1 <= 1'b1;
      dtack_s2 <= 1'b1;
    end else begin
      dtack_s1 <= bus._dtack;
      dtack_s2 <= dtack_s1;
    end
  end

  always_ff @(posedge clk) begin
    if (!_reset) begin
      state        <= ST_IDLE;
      lat_we       <= 1'b0;
      lat_bs       <= 2'b00;
      lat_wdat     <= '0;
      bus._as      <= 1'b1;
      bus._uds     <= 1'b1;
      bus._lds     <= 1'b1;
      bus.r_w      <= 1'b1;
      bus.address  <= '0;
      bus.data_out <= '0;
      bus.data_oe  <= 1'b0;
      req_rdat     <= '0;
      req_ack      <= 1'b0;
      req_err      <= 1'b0;
      busy         <= 1'b0;
`ifdef BUS_TIMEOUT_EN
      wait_cnt     <= '0;
      timed_out    <= 1'b0;
`endif
    end else begin
      req_ack <= 1'b0;
      req_err <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (clk7_en && req) begin
            if (req_bs == 2'b00) begin
              // Nothing to strobe: reject without touching the bus.
              req_err <= 1'b1;
            end else begin
              lat_we      <= req_we;
              lat_bs      <= req_bs;
              lat_wdat    <= req_wdat;
              bus.address <= req_adr;
              bus.r_w     <= ~req_we;
              busy        <= 1'b1;
              state       <= ST_S0;
`ifdef BUS_TIMEOUT_EN
              wait_cnt    <= '0;
              timed_out   <= 1'b0;
`endif
            end
          end
        end

        ST_S0: begin
          if (tick) state <= ST_S1;
        end

        ST_S1: begin
          if (tick) begin
            state   <= ST_S2;
            bus._as <= 1'b0;
            if (!lat_we) begin
              bus._uds <= ~lat_bs[1];
              bus._lds <= ~lat_bs[0];
            end
          end
        end

        ST_S2: begin
          if (tick) begin
            state <= ST_S3;
            if (lat_we) begin
              bus.data_out <= lat_wdat;
              bus.data_oe  <= 1'b1;
            end
          end
        end

        ST_S3: begin
          if (tick) begin
            state <= ST_S4;
            if (lat_we) begin
              bus._uds <= ~lat_bs[1];
              bus._lds <= ~lat_bs[0];
            end
          end
        end

        // Accept is always on clk7_en, so the tick that ends S4 is clk7n_en.
        ST_S4: begin
          if (tick) state <= dtack_s2 ? ST_WAIT : ST_S5;
        end

        // _dtack is only looked at on clk7n_en so wait states come in whole
        // 7 MHz clocks; a late _dtack wins over a timeout on the same tick.
        ST_WAIT: begin
          if (tick) begin
            if (clk7n_en && !dtack_s2) begin
              state <= ST_S5;
            end
`ifdef BUS_TIMEOUT_EN
            else if (wait_cnt == WAIT_LAST) begin
              state     <= ST_S7;
              timed_out <= 1'b1;
            end
            wait_cnt <= wait_cnt + 1'b1;
`endif
          end
        end

        ST_S5: begin
          if (tick) state <= ST_S6;
        end

        ST_S6: begin
          if (tick) begin
            state <= ST_S7;
            if (!lat_we) req_rdat <= bus.data_in;
          end
        end

        ST_S7: begin
          if (tick) begin
            state    <= ST_DONE;
            bus._as  <= 1'b1;
            bus._uds <= 1'b1;
            bus._lds <= 1'b1;
            bus.r_w  <= 1'b1;
          end
        end

        ST_DONE: begin
          state       <= ST_IDLE;
          bus.data_oe <= 1'b0;
          busy        <= 1'b0;
`ifdef BUS_TIMEOUT_EN
          if (timed_out) req_err <= 1'b1;
          else           req_ack <= 1'b1;
`else
          req_ack <= 1'b1;
`endif
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
